// File: rtl/rvga_types_pkg.sv
// Shared types for the data-memory path: word/line widths, funct3 encodings,
// the line-buffer FSM states and the captured request record.
package rvga_types;

   typedef logic [31:0]  rvga_word;
   typedef logic [127:0] rvga_cacheline;
   typedef logic [2:0]   rvga_funct3;
   typedef logic [27:0]  rvga_line_tag;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } rvga_ldop_e;

   typedef enum logic [2:0] {
      ST_SB = 3'b000,
      ST_SH = 3'b001,
      ST_SW = 3'b010
   } rvga_strop_e;

   typedef enum logic [2:0] {
      DMEM_IDLE      = 3'd0,
      DMEM_WB_REQ    = 3'd1,
      DMEM_FILL_REQ  = 3'd2,
      DMEM_FILL_WAIT = 3'd3,
      DMEM_RESP      = 3'd4
   } rvga_dmem_state_e;

   typedef struct packed {
      logic       w;
      rvga_funct3 funct3;
      rvga_word   addr;
      rvga_word   data;
   } rvga_dmem_req;

endpackage

// File: rtl/rvga_dmem_align.sv
// Lane logic for one access against a 128-bit line: alignment/funct3 error
// check, extended load extraction and byte/half/word store merge.
module rvga_dmem_align
   import rvga_types::*;
(
   input  rvga_cacheline line,
   input  logic [3:0]    addr,
   input  rvga_funct3    funct3,
   input  logic          w,
   input  rvga_word      store_data,
   output rvga_word      load_data,
   output rvga_cacheline merged_line,
   output logic          err
);

   rvga_word    word;
   rvga_word    new_word;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Select the addressed word and lanes, then extend loads or merge stores.
   always_comb begin
      word        = line[{addr[3:2], 5'b0} +: 32];
      lane_b      = word[{addr[1:0], 3'b0} +: 8];
      lane_h      = word[{addr[1], 4'b0} +: 16];
      err         = 1'b0;
      load_data   = '0;
      new_word    = word;
      merged_line = line;
      if (w) begin
         case (funct3)
            ST_SB: new_word[{addr[1:0], 3'b0} +: 8] = store_data[7:0];
            ST_SH: begin
               err = addr[0];
               new_word[{addr[1], 4'b0} +: 16] = store_data[15:0];
            end
            ST_SW: begin
               err      = |addr[1:0];
               new_word = store_data;
            end
            default: err = 1'b1;
         endcase
      end else begin
         case (funct3)
            LD_LB:  load_data = {{24{lane_b[7]}}, lane_b};
            LD_LBU: load_data = {24'b0, lane_b};
            LD_LH: begin
               err       = addr[0];
               load_data = {{16{lane_h[15]}}, lane_h};
            end
            LD_LHU: begin
               err       = addr[0];
               load_data = {16'b0, lane_h};
            end
            LD_LW: begin
               err       = |addr[1:0];
               load_data = word;
            end
            default: err = 1'b1;
         endcase
      end
      merged_line[{addr[3:2], 5'b0} +: 32] = new_word;
   end

endmodule

// File: rtl/rvga_dmem_linebuf.sv
// Single-line write-back buffer answering memory-stage loads/stores; misses
// write back a dirty line, fill from backing memory, then replay the request.
module rvga_dmem_linebuf
   import rvga_types::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_v_i,
   output logic          req_ready_o,
   input  logic          req_w_i,
   input  rvga_funct3    req_funct3_i,
   input  rvga_word      req_addr_i,
   input  rvga_word      req_data_i,
   output logic          resp_v_o,
   output rvga_word      resp_data_o,
   output logic          resp_err_o,
   output logic          mem_v_o,
   input  logic          mem_ready_i,
   output logic          mem_w_o,
   output rvga_word      mem_addr_o,
   output rvga_cacheline mem_data_o,
   input  logic          mem_resp_v_i,
   input  rvga_cacheline mem_data_i
);

   rvga_dmem_state_e state, state_next;
   rvga_cacheline    line;
   rvga_line_tag     tag;
   logic             valid, dirty;
   rvga_dmem_req     cap;

   logic          accept, hit, miss;
   logic [3:0]    al_addr;
   rvga_funct3    al_funct3;
   logic          al_w;
   rvga_word      al_data;
   rvga_word      al_load;
   rvga_cacheline al_line;
   logic          al_err;

   assign req_ready_o = (state == DMEM_IDLE);
   assign accept      = req_v_i & req_ready_o;
   assign hit         = valid && (tag == req_addr_i[31:4]);
   assign miss        = accept && !al_err && !hit;

   // The lane unit sees the live request in IDLE and the captured one on replay.
   always_comb begin
      al_addr   = req_addr_i[3:0];
      al_funct3 = req_funct3_i;
      al_w      = req_w_i;
      al_data   = req_data_i;
      if (state == DMEM_RESP) begin
         al_addr   = cap.addr[3:0];
         al_funct3 = cap.funct3;
         al_w      = cap.w;
         al_data   = cap.data;
      end
   end

   rvga_dmem_align u_align (
      .line        (line),
      .addr        (al_addr),
      .funct3      (al_funct3),
      .w           (al_w),
      .store_data  (al_data),
      .load_data   (al_load),
      .merged_line (al_line),
      .err         (al_err)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DMEM_IDLE;
      else        state <= state_next;
   end

   // Next state and memory-port drive; request fields are held by state alone.
   always_comb begin
      state_next = state;
      mem_v_o    = 1'b0;
      mem_w_o    = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      case (state)
         DMEM_IDLE: begin
            if (miss) state_next = (valid && dirty) ? DMEM_WB_REQ : DMEM_FILL_REQ;
         end
         DMEM_WB_REQ: begin
            mem_v_o    = 1'b1;
            mem_w_o    = 1'b1;
            mem_addr_o = {tag, 4'b0};
            mem_data_o = line;
            if (mem_ready_i) state_next = DMEM_FILL_REQ;
         end
         DMEM_FILL_REQ: begin
            mem_v_o    = 1'b1;
            mem_addr_o = {cap.addr[31:4], 4'b0};
            if (mem_ready_i) state_next = DMEM_FILL_WAIT;
         end
         DMEM_FILL_WAIT: begin
            if (mem_resp_v_i) state_next = DMEM_RESP;
         end
         DMEM_RESP:  state_next = DMEM_IDLE;
         default:    state_next = DMEM_IDLE;
      endcase
   end

   // Line contents, tag/valid/dirty, captured request and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line        <= '0;
         tag         <= '0;
         valid       <= 1'b0;
         dirty       <= 1'b0;
         cap         <= '0;
         resp_v_o    <= 1'b0;
         resp_data_o <= '0;
         resp_err_o  <= 1'b0;
      end else begin
         resp_v_o    <= 1'b0;
         resp_data_o <= '0;
         resp_err_o  <= 1'b0;
         if (accept) begin
            if (al_err) begin
               resp_v_o   <= 1'b1;
               resp_err_o <= 1'b1;
            end else if (hit) begin
               resp_v_o <= 1'b1;
               if (req_w_i) begin
                  line  <= al_line;
                  dirty <= 1'b1;
               end else begin
                  resp_data_o <= al_load;
               end
            end else begin
               cap.w      <= req_w_i;
               cap.funct3 <= req_funct3_i;
               cap.addr   <= req_addr_i;
               cap.data   <= req_data_i;
            end
         end
         if (state == DMEM_FILL_WAIT && mem_resp_v_i) begin
            line  <= mem_data_i;
            tag   <= cap.addr[31:4];
            valid <= 1'b1;
            dirty <= 1'b0;
         end
         if (state == DMEM_RESP) begin
            resp_v_o <= 1'b1;
            if (cap.w) begin
               line  <= al_line;
               dirty <= 1'b1;
            end else begin
               resp_data_o <= al_load;
            end
         end
      end
   end

endmodule
